// File: rtl/instruction_fd.sv
// instruction_fd: single-cycle RV64I-subset fetch and datapath steered by an external control unit.
// Holds the PC, instruction ROM, field/immediate decode, 32-entry regfile, add/sub ALU, branch compare and data RAM.
module instruction_fd #(
  parameter int XLEN       = 64,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WE_mem,
  input  logic            WE_reg,
  input  logic [1:0]      OP_MEM_I,
  input  logic            ADD_SUB,
  input  logic            PC_load,
  input  logic [2:0]      select_flags,
  output logic [5:0]      pc_out,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] wb_data,
  output logic            branch_taken
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] OPSEL_REG  = 2'd0;
  localparam logic [1:0] OPSEL_MEM  = 2'd1;
  localparam logic [1:0] OPSEL_IMM  = 2'd2;
  localparam logic [1:0] OPSEL_LINK = 2'd3;

  localparam logic [2:0] BR_EQ  = 3'd1;
  localparam logic [2:0] BR_NE  = 3'd2;
  localparam logic [2:0] BR_LT  = 3'd3;
  localparam logic [2:0] BR_GE  = 3'd4;
  localparam logic [2:0] BR_LTU = 3'd5;
  localparam logic [2:0] BR_GEU = 3'd6;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Branch offsets count instructions, so imm[3:0] lives in inst[11:8] rather than the usual byte layout.
  function automatic logic [31:0] enc_b(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], opc};
  endfunction

  function automatic logic [31:0] rom_word(input logic [PC_W-1:0] idx);
    logic [31:0] w;
    w = NOP;
    case (int'(idx))
      0:       w = enc_i(12'd1, 5'd0, F3_D, 5'd1, OPC_LOAD);
      1:       w = enc_i(12'd2, 5'd0, F3_D, 5'd2, OPC_LOAD);
      2:       w = enc_r(F7_ADD, 5'd2, 5'd1, F3_ADD, 5'd3, OPC_OP);
      3:       w = enc_r(F7_SUB, 5'd1, 5'd3, F3_ADD, 5'd4, OPC_OP);
      4:       w = enc_s(12'd3, 5'd3, 5'd0, F3_D, OPC_STORE);
      5:       w = enc_s(12'd4, 5'd4, 5'd0, F3_D, OPC_STORE);
      6:       w = enc_i(12'd10, 5'd4, F3_ADD, 5'd9, OPC_OPIMM);
      7:       w = enc_s(12'd9, 5'd9, 5'd0, F3_D, OPC_STORE);
      8:       w = enc_b(12'd2, 5'd3, 5'd3, F3_BEQ, OPC_BRANCH);
      9:       w = enc_i(12'd1, 5'd0, F3_ADD, 5'd5, OPC_OPIMM);
      10:      w = enc_r(F7_ADD, 5'd2, 5'd1, F3_ADD, 5'd5, OPC_OP);
      default: w = NOP;
    endcase
    return w;
  endfunction

  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  // RAM keeps its contents across reset; only the power-up image seeds it.
  logic [XLEN-1:0] ram_q [DMEM_DEPTH] = '{1: XLEN'(10), 2: XLEN'(20), default: '0};
  logic [XLEN-1:0] ram_d [DMEM_DEPTH];

  logic [31:0]     instr;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [DA_W-1:0] ram_addr;
  logic [XLEN-1:0] ram_rdata;
  logic            taken;
  logic [XLEN-1:0] wb;

  always_comb begin
    instr = rom_word(pc_q);
    rd    = instr[11:7];
    rs1   = instr[19:15];
    rs2   = instr[24:20];
  end

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:           imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:          imm = {{(XLEN-12){instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8]};
      default:             imm = '0;
    endcase
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  end

  always_comb begin
    alu_b      = (OP_MEM_I == OPSEL_REG) ? rs2_data : imm;
    alu_result = ADD_SUB ? (rs1_data - alu_b) : (rs1_data + alu_b);
    ram_addr   = alu_result[DA_W-1:0];
    ram_rdata  = ram_q[ram_addr];
  end

  // Undefined selector codes, including X, fall to the never-taken default.
  always_comb begin
    taken = 1'b0;
    case (select_flags)
      BR_EQ:   taken = (rs1_data == rs2_data);
      BR_NE:   taken = (rs1_data != rs2_data);
      BR_LT:   taken = ($signed(rs1_data) < $signed(rs2_data));
      BR_GE:   taken = ($signed(rs1_data) >= $signed(rs2_data));
      BR_LTU:  taken = (rs1_data < rs2_data);
      BR_GEU:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb = alu_result;
    case (OP_MEM_I)
      OPSEL_REG:  wb = alu_result;
      OPSEL_MEM:  wb = ram_rdata;
      OPSEL_IMM:  wb = alu_result;
      OPSEL_LINK: wb = XLEN'(pc_q) + XLEN'(1);
      default:    wb = alu_result;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PC_load) begin
      pc_d = taken ? (pc_q + imm[PC_W-1:0]) : (pc_q + PC_W'(1));
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (WE_reg && (rd != 5'd0)) begin
      regs_d[rd] = wb;
    end
  end

  always_comb begin
    ram_d = ram_q;
    if (WE_mem && !reset) begin
      ram_d[ram_addr] = rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      regs_q <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  assign pc_out       = 6'(pc_q);
  assign instr_out    = instr;
  assign wb_data      = wb;
  assign branch_taken = taken;

endmodule

// File: tb/tb_instruction_fd.sv
// tb_instruction_fd: drives instruction_fd through the default program and random control,
// comparing every observed output with an ISA-level model of PC, registers and RAM.
module tb_instruction_fd;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE_mem;
  logic        WE_reg;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;
  logic        PC_load;
  logic [2:0]  select_flags;
  logic [5:0]  pc_out;
  logic [31:0] instr_out;
  logic [63:0] wb_data;
  logic        branch_taken;

  instruction_fd #(.XLEN(64), .IMEM_DEPTH(32), .DMEM_DEPTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .WE_mem       (WE_mem),
    .WE_reg       (WE_reg),
    .OP_MEM_I     (OP_MEM_I),
    .ADD_SUB      (ADD_SUB),
    .PC_load      (PC_load),
    .select_flags (select_flags),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .wb_data      (wb_data),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          pc_m;
  logic [63:0] regs_m [32];
  logic [63:0] ram_m  [32];
  logic [31:0] rom_m  [32];

  logic [31:0] exp_instr;
  logic [63:0] exp_wb;
  logic        exp_bt;
  int          exp_next_pc;
  int          exp_addr;
  int          exp_rd;
  logic [63:0] exp_store;

  function automatic longint imm_of(input logic [31:0] w);
    logic [11:0] t;
    case (w[6:0])
      7'b0000011, 7'b0010011: t = w[31:20];
      7'b0100011:             t = {w[31:25], w[11:7]};
      7'b1100011:             t = {w[31], w[7], w[30:25], w[11:8]};
      default:                t = 12'd0;
    endcase
    return longint'($signed(t));
  endfunction

  task automatic model_eval();
    logic [31:0] w;
    logic [63:0] a, r2, b, alu;
    longint      imm;
    w         = rom_m[pc_m];
    exp_instr = w;
    a         = regs_m[w[19:15]];
    r2        = regs_m[w[24:20]];
    imm       = imm_of(w);
    b         = (OP_MEM_I == 2'd0) ? r2 : 64'(imm);
    alu       = ADD_SUB ? (a - b) : (a + b);
    exp_addr  = int'(alu & 64'd31);
    exp_store = r2;
    exp_rd    = int'(w[11:7]);
    case (OP_MEM_I)
      2'd1:    exp_wb = ram_m[exp_addr];
      2'd3:    exp_wb = 64'(pc_m + 1);
      default: exp_wb = alu;
    endcase
    case (select_flags)
      3'd1:    exp_bt = (a == r2);
      3'd2:    exp_bt = (a != r2);
      3'd3:    exp_bt = ($signed(a) < $signed(r2));
      3'd4:    exp_bt = ($signed(a) >= $signed(r2));
      3'd5:    exp_bt = (a < r2);
      3'd6:    exp_bt = (a >= r2);
      default: exp_bt = 1'b0;
    endcase
    if (!PC_load)    exp_next_pc = pc_m;
    else if (exp_bt) exp_next_pc = int'((longint'(pc_m) + imm) & 64'd31);
    else             exp_next_pc = (pc_m + 1) % 32;
  endtask

  task automatic model_commit();
    if (reset) begin
      pc_m = 0;
      for (int i = 0; i < 32; i++) regs_m[i] = '0;
    end else begin
      if (WE_reg && exp_rd != 0) regs_m[exp_rd] = exp_wb;
      if (WE_mem) ram_m[exp_addr] = exp_store;
      pc_m = exp_next_pc;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we_mem, input logic we_reg,
                               input logic [1:0] op, input logic as, input logic pl,
                               input logic [2:0] sel);
    reset        = rst;
    WE_mem       = we_mem;
    WE_reg       = we_reg;
    OP_MEM_I     = op;
    ADD_SUB      = as;
    PC_load      = pl;
    select_flags = sel;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 3'd0);
    tick();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    checks++;
    if (pc_out !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc_out);
    end
    checks++;
    if (instr_out !== 32'h00103083) begin
      errors++; $display("[TB] FAIL reset_instr: got %h expected 00103083", instr_out);
    end
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_branch: got %0b expected 0", branch_taken);
    end
    checks++;
    if (wb_data !== 64'd0) begin
      errors++; $display("[TB] FAIL reset_regs_zero: got %0h expected 0", wb_data);
    end
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd1);
    checks++;
    if (branch_taken !== exp_bt) begin
      errors++; $display("[TB] FAIL reset_eq_zero: got %0b expected %0b", branch_taken, exp_bt);
    end
    tick();
  endtask

  task automatic test_load();
    applyStimulus(0, 0, 1, 2'd1, 0, 1, 3'd0);
    checks++;
    if (wb_data !== 64'd10) begin
      errors++; $display("[TB] FAIL ld_x1: got %0d expected 10", wb_data);
    end
    tick();
    applyStimulus(0, 0, 1, 2'd1, 0, 1, 3'd0);
    checks++;
    if (wb_data !== 64'd20) begin
      errors++; $display("[TB] FAIL ld_x2: got %0d expected 20", wb_data);
    end
    tick();
    checks++;
    if (pc_out !== 6'd2) begin
      errors++; $display("[TB] FAIL ld_pc: got %0d expected 2", pc_out);
    end
  endtask

  task automatic test_alu();
    applyStimulus(0, 0, 1, 2'd0, 0, 1, 3'd0);
    checks++;
    if (wb_data !== 64'd30) begin
      errors++; $display("[TB] FAIL add_x3: got %0d expected 30", wb_data);
    end
    tick();
    applyStimulus(0, 0, 1, 2'd0, 1, 1, 3'd0);
    checks++;
    if (wb_data !== 64'd20) begin
      errors++; $display("[TB] FAIL sub_x4: got %0d expected 20", wb_data);
    end
    tick();
  endtask

  task automatic test_store();
    applyStimulus(0, 1, 0, 2'd1, 0, 1, 3'd0);
    checks++;
    if (wb_data !== exp_wb) begin
      errors++; $display("[TB] FAIL sd_x3_old: got %0h expected %0h", wb_data, exp_wb);
    end
    tick();
    applyStimulus(0, 1, 0, 2'd1, 0, 1, 3'd0);
    tick();
    applyStimulus(0, 0, 1, 2'd2, 0, 1, 3'd0);
    checks++;
    if (wb_data !== 64'd30) begin
      errors++; $display("[TB] FAIL addi_x9: got %0d expected 30", wb_data);
    end
    tick();
    applyStimulus(0, 1, 0, 2'd1, 0, 1, 3'd0);
    tick();
    checks++;
    if (pc_out !== 6'd8) begin
      errors++; $display("[TB] FAIL store_pc: got %0d expected 8", pc_out);
    end
  endtask

  task automatic test_branch();
    applyStimulus(0, 0, 0, 2'd0, 0, 1, 3'd1);
    checks++;
    if (branch_taken !== 1'b1) begin
      errors++; $display("[TB] FAIL beq_taken: got %0b expected 1", branch_taken);
    end
    tick();
    checks++;
    if (pc_out !== 6'd10) begin
      errors++; $display("[TB] FAIL beq_target: got %0d expected 10", pc_out);
    end
    applyStimulus(0, 0, 1, 2'd0, 0, 1, 3'd7);
    checks++;
    if (wb_data !== 64'd30 || branch_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL add_x5: got wb %0d bt %0b expected 30 0", wb_data, branch_taken);
    end
    tick();
    checks++;
    if (pc_out !== 6'd11) begin
      errors++; $display("[TB] FAIL sel7_pc: got %0d expected 11", pc_out);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'd2, 0, 0, 3'd1);
      tick();
      checks++;
      if (pc_out !== 6'd11) begin
        errors++; $display("[TB] FAIL hold_pc: got %0d expected 11", pc_out);
      end
    end
  endtask

  task automatic test_x0_write();
    applyStimulus(0, 0, 1, 2'd3, 0, 0, 3'd0);
    checks++;
    if (wb_data !== 64'd12) begin
      errors++; $display("[TB] FAIL link_value: got %0d expected 12", wb_data);
    end
    tick();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    checks++;
    if (wb_data !== 64'd0) begin
      errors++; $display("[TB] FAIL x0_read: got %0h expected 0", wb_data);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    applyStimulus(1, 1, 1, 2'd1, 0, 1, 3'd1);
    tick();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    checks++;
    if (pc_out !== 6'd0 || wb_data !== 64'd0) begin
      errors++; $display("[TB] FAIL mid_reset: got pc %0d wb %0h expected 0 0", pc_out, wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 2'd2, 0, 1, 3'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'd1, 0, 0, 3'd0);
    checks++;
    if (wb_data !== 64'd30) begin
      errors++; $display("[TB] FAIL ram3_kept: got %0d expected 30", wb_data);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'd2, 0, 1, 3'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'd1, 0, 0, 3'd0);
    checks++;
    if (wb_data !== 64'd30) begin
      errors++; $display("[TB] FAIL ram9_kept: got %0d expected 30", wb_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic        rst, wm, wr, as, pl;
    logic [1:0]  op;
    logic [2:0]  sel;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      op  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      wm  = (op != 2'd3) && ($urandom_range(0, 3) == 0);
      as  = 1'($urandom_range(0, 1));
      pl  = ($urandom_range(0, 7) != 0);
      sel = 3'($urandom_range(0, 7));
      applyStimulus(rst, wm, wr, op, as, pl, sel);
      checks++;
      if (pc_out !== 6'(pc_m)) begin
        errors++; $display("[TB] FAIL rnd_pc: got %0d expected %0d", pc_out, pc_m);
      end
      checks++;
      if (instr_out !== exp_instr) begin
        errors++; $display("[TB] FAIL rnd_instr: got %h expected %h", instr_out, exp_instr);
      end
      checks++;
      if (wb_data !== exp_wb) begin
        errors++; $display("[TB] FAIL rnd_wb: got %h expected %h", wb_data, exp_wb);
      end
      checks++;
      if (branch_taken !== exp_bt) begin
        errors++; $display("[TB] FAIL rnd_branch: got %0b expected %0b", branch_taken, exp_bt);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; WE_mem = 1'b0; WE_reg = 1'b0; OP_MEM_I = 2'd0;
    ADD_SUB = 1'b0; PC_load = 1'b0; select_flags = 3'd0;
    for (int i = 0; i < 32; i++) begin
      rom_m[i]  = 32'h00000013;
      ram_m[i]  = '0;
      regs_m[i] = '0;
    end
    rom_m[0]  = 32'h00103083;
    rom_m[1]  = 32'h00203103;
    rom_m[2]  = 32'h002081B3;
    rom_m[3]  = 32'h40118233;
    rom_m[4]  = 32'h003031A3;
    rom_m[5]  = 32'h00403223;
    rom_m[6]  = 32'h00A20493;
    rom_m[7]  = 32'h009034A3;
    rom_m[8]  = 32'h00318263;
    rom_m[9]  = 32'h00100293;
    rom_m[10] = 32'h002082B3;
    ram_m[1]  = 64'd10;
    ram_m[2]  = 64'd20;
    pc_m      = 0;
    @(negedge clk);
    test_reset();
    test_load();
    test_alu();
    test_store();
    test_branch();
    test_hold();
    test_x0_write();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
